button_reader: RTL and testbench
================================

// Module: button_reader
// PURPOSE
//  Input-side counterpart to the on-board LED driver. Samples N_BTN raw
//  front-panel pushbuttons/switches (asynchronous, bouncy, active-low on the
//  board), synchronises and debounces each one, and delivers clean levels,
//  single-cycle press/release strobes and per-button press counters to fabric
//  logic, e.g. to step the LED code or a test pattern.
// PARAMETERS
//  N_BTN           4           number of button channels
//  DEBOUNCE_CYCLES 27'd2000000 consecutive stable clk cycles to accept a change
//                              (10 ms at 200 MHz); legal range >= 1
//  ACTIVE_LOW      1           1: raw pin low = pressed; 0: raw pin high = pressed
//  CNT_W           4           width of each press counter
// PORTS
//  clk          in   1            system clock (200 MHz, from global clock buffer)
//  rst_in       in   1            synchronous, active-high reset
//  btn_raw      in   N_BTN        raw pad inputs, asynchronous to clk
//  btn_level    out  N_BTN        debounced level, 1 = pressed
//  btn_press    out  N_BTN        1-cycle strobe on accepted 0->1 of btn_level
//  btn_release  out  N_BTN        1-cycle strobe on accepted 1->0 of btn_level
//  press_cnt    out  N_BTN*CNT_W  per-channel press count; ch i at [i*CNT_W +: CNT_W]
//  any_press    out  1            OR of btn_press
// BEHAVIOUR
//  - Reset (rst_in high at a clk edge): sync regs, btn_level, btn_press,
//    btn_release, press_cnt, any_press and debounce counters all 0.
//    Synchroniser regs reset to the "released" value (0 after polarity fix).
//  - Polarity: p = ACTIVE_LOW ? ~btn_raw : btn_raw, before synchronisation.
//  - Sync: 2-flop synchroniser per channel (s1 -> s2); no logic between flops.
//  - Debounce per channel, counter dcnt width $clog2(DEBOUNCE_CYCLES+1):
//      s2 == btn_level                       : dcnt <= 0
//      s2 != btn_level, dcnt < DEBOUNCE_CYCLES-1 : dcnt <= dcnt+1
//      s2 != btn_level, dcnt == DEBOUNCE_CYCLES-1: btn_level <= s2, dcnt <= 0,
//                                              press/release strobe next edge
//    Any cycle of agreement restarts the count (glitch rejection).
//  - Latency: clean step on p visible on s2 after 2 edges; btn_level changes on
//    the DEBOUNCE_CYCLES-th edge after that; btn_press/btn_release registered
//    together with btn_level (same edge), high exactly 1 cycle.
//  - DEBOUNCE_CYCLES == 1: btn_level follows s2 with 1 cycle of delay.
//  - press_cnt[i] increments (mod 2^CNT_W, 2^CNT_W-1 -> 0) on the edge after
//    btn_press[i]; release does not count. Channels fully independent;
//    simultaneous presses all count and strobe in the same cycle.
//  - Button held through reset: after rst_in drops it is debounced as a new
//    press (strobe and count fire); no suppression.
//  - Reset mid-debounce: count discarded, level forced 0, no strobe emitted.
//  - any_press is combinational OR of registered btn_press.
// STRUCTURE
//  - Shared package (pkg_board_io): BOARD_CLK_HZ = 200_000_000,
//    DEBOUNCE_10MS = BOARD_CLK_HZ/100, board button count/polarity constants.
//  - Sub-module debounce_channel (one channel: sync, dcnt, level, strobes,
//    counter), instantiated N_BTN times in a generate loop; top does polarity,
//    port packing and any_press.
// TESTING  (bench uses DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, N_BTN=4, CNT_W=4)
//  1 reset, btn_raw=4'hF held -> all outputs 0; 20 cycles later still 0.
//  2 btn_raw[0] 1->0 clean step -> btn_level[0]=1 and btn_press[0]=1 exactly
//    10 edges after the step, strobe 1 cycle, press_cnt[0]=1 next cycle.
//  3 btn_raw[1] low 5 cycles, high 1, low 5 (bounce) -> no change; then low
//    held -> level rises 10 edges after the final low edge.
//  4 17 clean presses on ch2 -> press_cnt[2]=1 (wrap); release strobes 17,
//    ch0/1/3 counters unchanged.
//  5 ch0 and ch3 pressed on same edge -> both strobes same cycle, any_press 1
//    cycle, both counters +1.
//  6 rst_in pulsed at dcnt=5 during press, button held -> no strobe at reset,
//    level 0, then press accepted 10 edges after rst_in drops.

Source files
------------

// File: rtl/pkg_board_io.sv
// pkg_board_io
//   Board-level constants shared by the front-panel I/O blocks: the system
//   clock rate, the 10 ms debounce interval derived from it, the board's
//   button count, polarity and press-counter width, and a helper that sizes
//   debounce counters.
//   No ports (package).
package pkg_board_io;

    localparam int unsigned BOARD_CLK_HZ         = 200_000_000;
    localparam int unsigned DEBOUNCE_10MS        = BOARD_CLK_HZ / 100;
    localparam int unsigned BOARD_N_BTN          = 4;
    localparam bit          BOARD_BTN_ACTIVE_LOW = 1'b1;
    localparam int unsigned BOARD_CNT_W          = 4;

    // Bits needed for a counter that must be able to represent the value
    // "cycles". The counter itself only ever reaches cycles-1.
    function automatic int unsigned dcntWidth(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One button channel. It synchronises an already polarity-corrected pad
//   signal, debounces it, and produces a clean level, one-cycle press and
//   release strobes, and a wrapping press counter.
//   Ports:
//     clk       in   system clock
//     rst_in    in   synchronous active-high reset
//     p_i       in   pad level, 1 = pressed, asynchronous to clk
//     level_o   out  debounced level, 1 = pressed
//     press_o   out  1-cycle strobe when level_o goes 0->1
//     release_o out  1-cycle strobe when level_o goes 1->0
//     cnt_o     out  press count, modulo 2^CNT_W
module debounce_channel
    import pkg_board_io::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned CNT_W           = BOARD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             p_i,
    output logic             level_o,
    output logic             press_o,
    output logic             release_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned   DW        = dcntWidth(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [DW-1:0]    dcnt_q;
    logic [DW-1:0]    dcnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchroniser. Nothing sits between s1 and s2, so s1 has a
    // full clock period to settle out of metastability. Reset loads the
    // "released" value, which means a button held through reset is seen as
    // a fresh press once reset drops.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= p_i;
            s2_q <= s1_q;
        end
    end

    // Debounce decision. The counter runs only while the synchronised input
    // disagrees with the accepted level. A single cycle of agreement drops
    // it back to zero, which is what rejects bounce. When it has disagreed
    // for DEBOUNCE_CYCLES consecutive edges, the new level is taken, and the
    // matching strobe is registered on that same edge. The press counter
    // uses the registered strobe, so it moves one edge after the press.
    always_comb begin
        dcnt_d    = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q != level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                level_d   = s2_q;
                press_d   = s2_q;
                release_d = ~s2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
        cnt_d = cnt_q + CNT_W'(press_q);
    end

    // State register for the debouncer, the strobes and the press counter.
    // Reset throws away any debounce in progress without emitting a strobe.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/button_reader.sv
// button_reader
//   Front-panel button input block. It corrects the pad polarity, then runs
//   one debounce_channel per button and packs the results onto flat buses.
//   Ports:
//     clk         in   system clock
//     rst_in      in   synchronous active-high reset
//     btn_raw     in   raw pad levels, asynchronous, polarity set by ACTIVE_LOW
//     btn_level   out  debounced levels, 1 = pressed
//     btn_press   out  1-cycle press strobes
//     btn_release out  1-cycle release strobes
//     press_cnt   out  per-channel press counters, channel i at [i*CNT_W +: CNT_W]
//     any_press   out  OR of all press strobes
module button_reader
    import pkg_board_io::*;
#(
    parameter int unsigned N_BTN           = BOARD_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter bit          ACTIVE_LOW      = BOARD_BTN_ACTIVE_LOW,
    parameter int unsigned CNT_W           = BOARD_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic [N_BTN-1:0]       btn_raw,
    output logic [N_BTN-1:0]       btn_level,
    output logic [N_BTN-1:0]       btn_press,
    output logic [N_BTN-1:0]       btn_release,
    output logic [N_BTN*CNT_W-1:0] press_cnt,
    output logic                   any_press
);

    logic [N_BTN-1:0] pressedRaw;

    // Polarity is fixed ahead of the synchroniser so that every channel
    // works with 1 = pressed. The inverter is in front of the first flop,
    // so there is still no logic between the two synchroniser stages.
    assign pressedRaw = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Channels are fully independent. Simultaneous presses strobe and count
    // in the same cycle.
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst_in   (rst_in),
            .p_i      (pressedRaw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .cnt_o    (press_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Combinational OR of the registered strobes. It needs no register of
    // its own because its inputs are already registered.
    assign any_press = |btn_press;

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader
//   Self-checking bench for button_reader with DEBOUNCE_CYCLES=8,
//   ACTIVE_LOW=1, N_BTN=4 and CNT_W=4. A behavioural model keeps the last
//   DEBOUNCE_CYCLES synchronised samples of each channel and accepts a new
//   level when all of them oppose the current one. Every output is compared
//   with the model after each clock edge. Directed scenarios and a random
//   bouncy phase supply the stimulus.
module tb_button_reader;

    localparam int NB = 4;
    localparam int DC = 8;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_in;
    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    btn_level;
    logic [NB-1:0]    btn_press;
    logic [NB-1:0]    btn_release;
    logic [NB*CW-1:0] press_cnt;
    logic             any_press;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic          mS1   [NB];
    logic          mS2   [NB];
    logic [DC-1:0] mHist [NB];
    logic [CW-1:0] mCnt  [NB];
    logic [NB-1:0] mLevel;
    logic [NB-1:0] mPress;
    logic [NB-1:0] mRelease;

    button_reader #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC),
        .ACTIVE_LOW     (1'b1),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_cnt  (press_cnt),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] raw, input logic rst);
        btn_raw = raw;
        rst_in  = rst;
    endtask

    // Advances the model by one clock edge, using the inputs the DUT saw on
    // that same edge.
    task automatic modelEdge();
        for (int ch = 0; ch < NB; ch++) begin
            logic [DC-1:0] w;
            if (rst_in) begin
                mS1[ch]      = 1'b0;
                mS2[ch]      = 1'b0;
                mHist[ch]    = '0;
                mCnt[ch]     = '0;
                mLevel[ch]   = 1'b0;
                mPress[ch]   = 1'b0;
                mRelease[ch] = 1'b0;
            end else begin
                mCnt[ch]  = mCnt[ch] + CW'(mPress[ch]);
                w         = {mHist[ch][DC-2:0], mS2[ch]};
                mHist[ch] = w;
                if (w == {DC{~mLevel[ch]}}) begin
                    mPress[ch]   = ~mLevel[ch];
                    mRelease[ch] = mLevel[ch];
                    mLevel[ch]   = ~mLevel[ch];
                end else begin
                    mPress[ch]   = 1'b0;
                    mRelease[ch] = 1'b0;
                end
                mS2[ch] = mS1[ch];
                mS1[ch] = ~btn_raw[ch];
            end
        end
    endtask

    task automatic stepCycle();
        logic [NB*CW-1:0] expCnt;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        for (int ch = 0; ch < NB; ch++) expCnt[ch*CW +: CW] = mCnt[ch];
        checkOutput("level",   32'(btn_level),   32'(mLevel));
        checkOutput("press",   32'(btn_press),   32'(mPress));
        checkOutput("release", 32'(btn_release), 32'(mRelease));
        checkOutput("cnt",     32'(press_cnt),   32'(expCnt));
        checkOutput("any",     32'(any_press),   32'(|mPress));
    endtask

    task automatic waitLevel(input int ch, input logic want, output int edges);
        edges = 0;
        for (int k = 0; k < 40; k++) begin
            stepCycle();
            edges++;
            if (btn_level[ch] == want) break;
        end
    endtask

    initial begin
        int edges;
        int relCount;
        int anyCount;
        logic [NB-1:0] target;
        logic [NB-1:0] raw;

        // 1: reset with all buttons released
        applyStimulus(4'hF, 1'b1);
        repeat (3) stepCycle();
        checkOutput("t1_level_rst", 32'(btn_level), 32'h0);
        applyStimulus(4'hF, 1'b0);
        repeat (20) stepCycle();
        checkOutput("t1_level_idle", 32'(btn_level), 32'h0);
        checkOutput("t1_cnt_idle", 32'(press_cnt), 32'h0);

        // 2: clean press on channel 0
        applyStimulus(4'hE, 1'b0);
        waitLevel(0, 1'b1, edges);
        checkOutput("t2_latency", 32'(edges), 32'd10);
        checkOutput("t2_press", 32'(btn_press[0]), 32'h1);
        stepCycle();
        checkOutput("t2_strobe_width", 32'(btn_press[0]), 32'h0);
        checkOutput("t2_cnt", 32'(press_cnt[3:0]), 32'h1);

        // 3: bouncy press on channel 1
        applyStimulus(4'hC, 1'b0);
        repeat (5) stepCycle();
        applyStimulus(4'hE, 1'b0);
        stepCycle();
        checkOutput("t3_no_early", 32'(btn_level[1]), 32'h0);
        applyStimulus(4'hC, 1'b0);
        waitLevel(1, 1'b1, edges);
        checkOutput("t3_latency", 32'(edges), 32'd10);
        stepCycle();
        checkOutput("t3_cnt", 32'(press_cnt[7:4]), 32'h1);
        applyStimulus(4'hF, 1'b0);
        repeat (12) stepCycle();
        checkOutput("t3_released", 32'(btn_level), 32'h0);

        // 4: 17 presses on channel 2 wrap its counter to 1
        relCount = 0;
        for (int n = 0; n < 17; n++) begin
            applyStimulus(4'hB, 1'b0);
            repeat (12) begin
                stepCycle();
                if (btn_release[2]) relCount++;
            end
            applyStimulus(4'hF, 1'b0);
            repeat (12) begin
                stepCycle();
                if (btn_release[2]) relCount++;
            end
        end
        checkOutput("t4_releases", 32'(relCount), 32'd17);
        checkOutput("t4_cnt", 32'(press_cnt), 32'h0111);

        // 5: channels 0 and 3 pressed on the same edge
        applyStimulus(4'h6, 1'b0);
        anyCount = 0;
        repeat (14) begin
            stepCycle();
            if (any_press) begin
                anyCount++;
                checkOutput("t5_both", 32'(btn_press), 32'h9);
            end
        end
        checkOutput("t5_any_cycles", 32'(anyCount), 32'd1);
        checkOutput("t5_cnt", 32'(press_cnt), 32'h1112);
        applyStimulus(4'hF, 1'b0);
        repeat (12) stepCycle();

        // 6: reset mid-debounce with the button held
        applyStimulus(4'hD, 1'b0);
        repeat (7) stepCycle();
        applyStimulus(4'hD, 1'b1);
        stepCycle();
        checkOutput("t6_level_rst", 32'(btn_level), 32'h0);
        checkOutput("t6_press_rst", 32'(btn_press), 32'h0);
        checkOutput("t6_cnt_rst", 32'(press_cnt), 32'h0);
        applyStimulus(4'hD, 1'b0);
        waitLevel(1, 1'b1, edges);
        checkOutput("t6_latency", 32'(edges), 32'd10);
        checkOutput("t6_press", 32'(btn_press[1]), 32'h1);
        stepCycle();
        checkOutput("t6_cnt", 32'(press_cnt), 32'h0010);
        applyStimulus(4'hF, 1'b0);
        repeat (12) stepCycle();

        // Random bouncy buttons with occasional resets
        target = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if ($urandom_range(0, 39) == 0) target[ch] = ~target[ch];
                raw[ch] = target[ch];
                if ($urandom_range(0, 7) == 0) raw[ch] = ~target[ch];
            end
            applyStimulus(raw, ($urandom_range(0, 599) == 0));
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
